// File: rtl/irq_arbiter.sv
// irq_arbiter: edge-triggered interrupt sources -> pending latch -> fixed-priority
// (index 0 highest) single-outstanding request to the core-local interruptor.
// Latency: rise at edge t sets pending at t; int_flag valid after edge t+1.
// Backpressure: one interrupt in flight; others stay pending until int_done.
// Ports:
//   clk, rst_n           clock, async active-low reset
//   irq_src[N_SRC]       level source lines, a rising edge requests
//   cfg_we/addr/wdata    config write port; cfg_rdata combinational from cfg_addr
//                        (0 ENABLE rw, 1 PENDING W1C, 2 ACTIVE_ID ro, 3 zero)
//   int_flag[ID_W]       registered request code, 0 none, k+1 = source k
//   int_ack, int_done    one-cycle pulses: interrupt taken / mret executed
//   busy                 registered, high while presented or in service
module irq_arbiter #(
  parameter int N_SRC = 8,
  parameter int ID_W  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_SRC-1:0] irq_src,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_addr,
  input  logic [15:0]      cfg_wdata,
  output logic [15:0]      cfg_rdata,
  output logic [ID_W-1:0]  int_flag,
  input  logic             int_ack,
  input  logic             int_done,
  output logic             busy
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_ACTIVE} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [N_SRC-1:0] r_prev;
  logic [N_SRC-1:0] r_pending;
  logic [N_SRC-1:0] r_enable;
  logic             r_armed;
  logic [ID_W-1:0]  r_cur_id;
  logic [ID_W-1:0]  r_int_flag;
  logic             r_busy;

  logic [N_SRC-1:0] w_rise;
  logic             w_wr_en;
  logic             w_wr_pend;
  logic [N_SRC-1:0] w_enable_nxt;
  logic [N_SRC-1:0] w_w1c;
  logic [N_SRC-1:0] w_cur_mask;
  logic             w_take;
  logic [N_SRC-1:0] w_pend_kept;
  logic [N_SRC-1:0] w_pending_nxt;
  logic [N_SRC-1:0] w_req_vec;
  logic             w_any;
  logic [ID_W-1:0]  w_win;
  logic             w_withdraw;
  logic [ID_W-1:0]  w_cur_nxt;
  logic [ID_W-1:0]  w_flag_nxt;
  logic             w_unused_wdata;

  // r_armed stays low for the first edge after reset so that a source held
  // high through reset release only loads prev and must toggle to request.
  assign w_rise = irq_src & ~r_prev & {N_SRC{r_armed}};

  assign w_wr_en      = cfg_we && (cfg_addr == 2'd0);
  assign w_wr_pend    = cfg_we && (cfg_addr == 2'd1);
  assign w_enable_nxt = w_wr_en ? cfg_wdata[N_SRC-1:0] : r_enable;
  assign w_w1c        = w_wr_pend ? cfg_wdata[N_SRC-1:0] : '0;
  assign w_cur_mask   = N_SRC'(1) << r_cur_id;
  assign w_take       = (r_state == S_REQ) && int_ack;

  // A new rise always beats any clear of the same bit in the same cycle.
  assign w_pend_kept   = (r_pending & ~w_w1c) | w_rise;
  assign w_pending_nxt = (r_pending & ~(w_w1c | (w_take ? w_cur_mask : '0))) | w_rise;

  // Withdrawal looks at the values about to be written, so a disable or
  // W1C drops int_flag on the very edge that performs the write.
  assign w_withdraw = ((w_enable_nxt & w_cur_mask) == '0) ||
                      ((w_pend_kept & w_cur_mask) == '0);

  assign w_req_vec = r_pending & r_enable;
  assign w_any     = |w_req_vec;

  // Lowest set index wins.
  always_comb begin
    w_win = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (w_req_vec[i]) w_win = ID_W'(i);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cur_nxt   = r_cur_id;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_state_nxt = S_REQ;
          w_cur_nxt   = w_win;
        end
      end
      S_REQ: begin
        if (int_ack)         w_state_nxt = S_ACTIVE;
        else if (w_withdraw) w_state_nxt = S_IDLE;
      end
      S_ACTIVE: begin
        if (int_done) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_flag_nxt = (w_state_nxt == S_REQ) ? (w_cur_nxt + ID_W'(1)) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_prev     <= '0;
      r_pending  <= '0;
      r_enable   <= '0;
      r_armed    <= 1'b0;
      r_cur_id   <= '0;
      r_int_flag <= '0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_prev     <= irq_src;
      r_pending  <= w_pending_nxt;
      r_enable   <= w_enable_nxt;
      r_armed    <= 1'b1;
      r_cur_id   <= w_cur_nxt;
      r_int_flag <= w_flag_nxt;
      r_busy     <= (w_state_nxt != S_IDLE);
    end
  end

  always_comb begin
    cfg_rdata = '0;
    case (cfg_addr)
      2'd0: cfg_rdata = 16'(r_enable);
      2'd1: cfg_rdata = 16'(r_pending);
      2'd2: if (r_state == S_ACTIVE) cfg_rdata = 16'(r_cur_id) + 16'd1;
      default: cfg_rdata = '0;
    endcase
  end

  // Write data bits above N_SRC have no register behind them.
  assign w_unused_wdata = &{1'b0, cfg_wdata};

  assign int_flag = r_int_flag;
  assign busy     = r_busy;

endmodule

// File: doc/irq_arbiter.md
IRQ_ARBITER -- requirements
Module: irq_arbiter

Interface
REQ-001 Parameter N_SRC, default 8: number of interrupt sources, legal range 1..15.
REQ-002 Parameter ID_W, default 4: width of int_flag; SHALL satisfy 2^ID_W > N_SRC.
REQ-003 clk  input  1  clock; all state SHALL update on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 irq_src  input  N_SRC  interrupt source lines, level; a source requests on a rising edge; synchronous to clk.
REQ-006 cfg_we  input  1  configuration write strobe.
REQ-007 cfg_addr  input  2  configuration register select.
REQ-008 cfg_wdata  input  16  configuration write data.
REQ-009 cfg_rdata  output  16  configuration read data, combinational from cfg_addr.
REQ-010 int_flag  output  ID_W  registered request code to the core-local interruptor; 0 means no interrupt; k+1 means source k.
REQ-011 int_ack  input  1  one-cycle pulse from the interruptor: the interrupt has been taken (entry sequence started).
REQ-012 int_done  input  1  one-cycle pulse from the interruptor: interrupt return (mret) executed.
REQ-013 busy  output  1  registered; high while an interrupt is presented or in service.

Function
REQ-014 Edge detect: the block SHALL register irq_src into prev; rise[i] = irq_src[i] & ~prev[i].
REQ-015 pending[i] SHALL be set on the clock edge at which rise[i] is seen; sources never drop a request silently.
REQ-016 Register map, 16-bit, bits above N_SRC read 0:
  - addr 0: ENABLE, read/write, mask bit per source.
  - addr 1: PENDING; a read returns pending; a write of 1 clears that bit (W1C).
  - addr 2: ACTIVE_ID, read-only, {12'b0, active code}; 0 when idle.
  - addr 3: reads 0; writes ignored.
REQ-017 FSM states: S_IDLE, S_REQ, S_ACTIVE.
REQ-018 In S_IDLE, when (pending & ENABLE) != 0:
  - the block SHALL latch cur_id = the lowest set index (index 0 has the highest priority);
  - it SHALL go to S_REQ and drive int_flag = cur_id+1 from the next cycle.
REQ-019 In S_REQ, int_flag SHALL hold constant until int_ack; the winner SHALL NOT change even if a higher-priority source becomes pending.
REQ-020 On int_ack in S_REQ:
  - pending[cur_id] SHALL clear;
  - the FSM SHALL go to S_ACTIVE;
  - int_flag SHALL return to 0 on the next edge.
REQ-021 In S_ACTIVE, int_flag SHALL stay 0 (no nesting). On int_done the FSM SHALL go to S_IDLE and ACTIVE_ID SHALL clear.
REQ-022 In S_REQ, if ENABLE[cur_id] is cleared before int_ack:
  - the request is withdrawn; the FSM SHALL go to S_IDLE and int_flag = 0 next cycle;
  - pending[cur_id] SHALL be kept.
REQ-023 In S_REQ, a W1C of pending[cur_id] SHALL also withdraw the request (same behaviour as REQ-022).
REQ-024 When a set and a clear of the same pending bit occur in the same cycle (rise versus ack-clear or W1C), set SHALL win.
REQ-025 int_ack outside S_REQ and int_done outside S_ACTIVE SHALL be ignored.
REQ-026 busy SHALL be high in S_REQ and S_ACTIVE.
REQ-027 Minimum latency: rise at edge t sets pending at t; S_REQ and int_flag valid after edge t+1.
REQ-028 After int_done, the next pending source SHALL be presented no earlier than the second edge after the done edge (one idle cycle).

Reset
REQ-029 While rst_n is low:
  - state = S_IDLE;
  - int_flag = 0, busy = 0;
  - pending = 0, ENABLE = 0, prev = 0, cur_id = 0.
REQ-030 Reset asserted mid-operation SHALL abort any request or service immediately, with no pulse on any output.
REQ-031 A source held high through reset release SHALL NOT create a request until it falls and rises again.

Verification
REQ-032 ENABLE=0x00FF; pulse irq_src[3] -> PENDING=0x0008; int_flag=4 two cycles later; int_ack -> int_flag=0, PENDING=0, ACTIVE_ID=4; int_done -> busy=0.
REQ-033 ENABLE=0x00FF; sources 5 and 2 rise together -> int_flag=3. After ack and done, int_flag=6 after one idle cycle.
REQ-034 ENABLE=0x0001; int_flag=1 presented; write ENABLE=0 before ack -> int_flag=0, state S_IDLE, PENDING bit0 still 1.
REQ-035 In S_REQ with cur_id=1, source 1 rises again in the same cycle as int_ack -> PENDING bit1 remains 1; after int_done, int_flag=2 again.
REQ-036 In S_ACTIVE, assert rst_n low -> int_flag=0, busy=0, all registers 0 asynchronously. Source held high across reset release -> no request.
